// File: rtl/visualizer_writer.sv
`default_nettype none
// ============================================================================
// Module   : visualizer_writer
// Purpose  : Queues bar-length updates for the visualizer row RAM and writes
//            them only during vertical blanking, so visible lines never see a
//            half-updated row. Also provides a blanking-paced sweep that
//            zeroes every row.
// Ports    : pixel_clk_in / rst_n_in   - clock, async active-low reset
//            vcount_in                 - current video line
//            upd_valid_in/upd_ready_out- update handshake
//            upd_idx_in/upd_value_in   - target row and raw bar length
//            clear_in / busy_out       - clear request / sweep in progress
//            tg_write_en/tg_addr/tg_input - registered row-RAM write port
//            drop_cnt_out              - saturating count of bad-index updates
// Revision : 1.0 - initial release
// ============================================================================
module visualizer_writer #(
  parameter int SCREEN_HEIGHT = 42,
  parameter int SCREEN_WIDTH  = 76,
  parameter int FIFO_DEPTH    = 4,
  parameter int ACTIVE_V      = 720,
  parameter int V_TOTAL       = 750
) (
  input  logic                             pixel_clk_in,
  input  logic                             rst_n_in,
  input  logic [9:0]                       vcount_in,
  input  logic                             upd_valid_in,
  output logic                             upd_ready_out,
  input  logic [$clog2(SCREEN_HEIGHT):0]   upd_idx_in,
  input  logic [31:0]                      upd_value_in,
  input  logic                             clear_in,
  output logic                             busy_out,
  output logic                             tg_write_en,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] tg_addr,
  output logic [31:0]                      tg_input,
  output logic [7:0]                       drop_cnt_out
);

  localparam int ADDR_W = $clog2(SCREEN_HEIGHT);
  localparam int IDX_W  = ADDR_W + 1;
  localparam int VAL_W  = $clog2(SCREEN_WIDTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [IDX_W-1:0]  c_height   = IDX_W'(SCREEN_HEIGHT);
  localparam logic [31:0]       c_width    = 32'(SCREEN_WIDTH);
  localparam logic [9:0]        c_blank_lo = 10'(ACTIVE_V);
  // Stop one line early so a write issued on the last blank line cannot
  // land while line 0 is being scanned.
  localparam logic [9:0]        c_blank_hi = 10'(V_TOTAL - 2);
  localparam logic [ADDR_W-1:0] c_last_row = ADDR_W'(SCREEN_HEIGHT - 1);
  localparam logic [PTR_W:0]    c_depth    = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [VAL_W-1:0]  val;
  } entry_t;

  state_t            r_state;
  state_t            w_state_next;
  entry_t            r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_sweep;
  logic [7:0]        r_drop_cnt;

  logic              w_blank;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_in_range;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic              w_clear_wr;
  logic [VAL_W-1:0]  w_clamped;
  entry_t            w_head;

  assign w_blank    = (vcount_in >= c_blank_lo) && (vcount_in <= c_blank_hi);
  assign w_full     = (r_count == c_depth);
  assign w_empty    = (r_count == '0);

  // Ready is gated by rst_n_in directly so it drops the instant reset is
  // asserted, not at the next clock edge.
  assign upd_ready_out = rst_n_in && !w_full && (r_state == ST_IDLE);

  assign w_accept   = upd_valid_in && upd_ready_out;
  assign w_in_range = (upd_idx_in < c_height);
  assign w_push     = w_accept && w_in_range;
  assign w_drop     = w_accept && !w_in_range;
  assign w_clamped  = (upd_value_in > c_width) ? VAL_W'(SCREEN_WIDTH)
                                               : upd_value_in[VAL_W-1:0];
  assign w_head     = r_fifo[r_rd_ptr];

  assign busy_out     = (r_state == ST_CLEAR);
  assign drop_cnt_out = r_drop_cnt;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_clear_wr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A pop may coincide with the clear request; its write lands one
        // cycle before the first sweep write, so the two never collide.
        w_pop = w_blank && !w_empty;
        if (clear_in) begin
          w_state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        // Queue is frozen during the sweep; it drains once IDLE resumes.
        w_clear_wr = w_blank;
        if (w_blank && (r_sweep == c_last_row)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Update queue
  // --------------------------------------------------------------------------
  always_ff @(posedge pixel_clk_in) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= '{idx: upd_idx_in[ADDR_W-1:0], val: w_clamped};
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sweep counter and drop counter
  // --------------------------------------------------------------------------
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sweep <= '0;
    end else if ((r_state == ST_IDLE) && clear_in) begin
      r_sweep <= '0;
    end else if (w_clear_wr) begin
      r_sweep <= (r_sweep == c_last_row) ? '0 : r_sweep + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Registered row-RAM write port; address/data hold between writes.
  // --------------------------------------------------------------------------
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tg_write_en <= 1'b0;
      tg_addr     <= '0;
      tg_input    <= '0;
    end else begin
      tg_write_en <= w_pop || w_clear_wr;
      if (w_pop) begin
        tg_addr  <= w_head.idx;
        tg_input <= 32'(w_head.val);
      end else if (w_clear_wr) begin
        tg_addr  <= r_sweep;
        tg_input <= '0;
      end
    end
  end

endmodule
`default_nettype wire
